dpram_loader: RTL and testbench
===============================

// Module: dpram_loader
// PURPOSE
//  Write-port sequencer for a generic dual-port RAM. Sits directly upstream of the RAM's A port:
//  clears the whole RAM after reset or on request, then accepts the HPS/APF byte download
//  stream, decodes it to the RAM window, packs bytes into RAM words and issues one write per word.
//  Port B of the RAM stays free for the game core.
// PARAMETERS
//  address_width  10        RAM word-address width (depth = 2**address_width)
//  data_width     8         RAM word width; 8 or 16 only (1 or 2 bytes per word)
//  base_addr      25'h0     first download byte address mapped to RAM word 0
//  clear_value    0         word value written during clear, data_width bits
// PORTS
//  clock        in   1    single clock; all logic on posedge
//  reset_n      in   1    synchronous, active-low reset
//  clear_req    in   1    one-cycle pulse: start a full clear (honoured in IDLE only)
//  dl_active    in   1    download in progress (level)
//  dl_wr        in   1    one download byte valid this cycle
//  dl_addr      in   25   byte address of dl_data
//  dl_data      in   8    download byte
//  dl_wait      out  1    high: source must hold off dl_wr
//  ram_wren     out  1    to RAM wren_a
//  ram_address  out  address_width  to RAM address_a
//  ram_data     out  data_width     to RAM data_a
//  busy         out  1    high in CLEAR, LOAD or FLUSH
//  done         out  1    one-cycle pulse at end of a clear or a load
//  overrun      out  1    sticky: dl_wr seen while dl_wait high; cleared by reset only
// BEHAVIOUR
//  - Reset: ram_wren=0, ram_address=0, ram_data=clear_value, dl_wait=1, busy=1, done=0,
//    overrun=0; state enters CLEAR with clear counter = 0 (auto-clear after every reset).
//  - States: CLEAR, IDLE, LOAD, FLUSH.
//  - CLEAR: one write per cycle, ram_address = counter, ram_data = clear_value;
//    2**address_width cycles in total. After the write to the last address: done pulse, -> IDLE.
//    dl_wait=1 throughout. A download starting mid-clear waits; clear is never aborted.
//  - IDLE: dl_wait=0, busy=0. dl_active=1 -> LOAD (takes priority over clear_req in the same cycle).
//    clear_req=1 -> CLEAR with counter reset to 0.
//  - LOAD: byte offset off = dl_addr - base_addr. A byte is in window when
//    dl_addr >= base_addr and off < 2**address_width * bytes_per_word; others are dropped silently.
//    16-bit: byte lane = off[0], little-endian (lane 0 = bits 7:0); word address = off >> 1.
//    8-bit: word address = off.
//    Write is issued on the byte that completes the word (lane 1, or every byte for 8-bit).
//    ram_wren is high exactly one cycle, the cycle after that dl_wr (1-cycle latency).
//    Lane 0 captured in a staging register; a lane-1 byte whose word address differs from the
//    staged one writes clear_value in lane 0.
//  - Staged lane 0 followed by a lane-0 byte to a different word: flush the staged word
//    (upper lane = clear_value[15:8]), then stage the new byte.
//  - dl_active falling in LOAD: if a lane-0 byte is staged -> FLUSH (one write, upper lane =
//    clear_value[15:8]), else none. Then done pulse, -> IDLE. dl_wait=1 in FLUSH.
//  - ram_address wraps never: out-of-window bytes are discarded, not aliased.
//  - reset_n low at any time, including mid-clear or mid-load: immediate return to reset values;
//    staged byte discarded; clear restarts from address 0.
//  - ram_wren=0 in IDLE. ram_address and ram_data hold their last value when ram_wren=0.
// STRUCTURE
//  - Shared package: state encoding localparams (ST_CLEAR, ST_IDLE, ST_LOAD, ST_FLUSH) and
//    BYTES_PER_WORD derivation.
//  - Single module, no sub-modules; the downstream RAM is instantiated by the parent, not here.
//  - Elaboration error if data_width is not 8 or 16.
// TESTING
//  1 Reset, aw=4, clear_value=8'hA5: 16 consecutive writes addr 0..15 data A5, done pulse on
//    the cycle after the last write, dl_wait=1 until IDLE.
//  2 dw=8, base=25'h100: bytes to 0x100..0x103 = 11,22,33,44 -> writes addr 0..3 with those
//    values, each 1 cycle after its dl_wr; byte at 0x0FF and at 0x100+16 dropped.
//  3 dw=16: bytes 0x00=34, 0x01=12 -> one write addr 0 data 16'h1234; no write after byte 0.
//  4 dw=16: single byte to offset 4 then dl_active falls -> FLUSH write addr 2 data
//    {clear_value[15:8],byte}, then done.
//  5 dl_active raised mid-clear with dl_wr pulses -> clear completes, overrun=1,
//    no download writes until IDLE/LOAD.
//  6 reset_n low for 1 cycle mid-load with lane 0 staged -> no flush write, clear restarts at addr 0.

Source files
------------

// File: rtl/dpram_loader_pkg.sv
// dpram_loader_pkg: state encoding and word-size helpers for the
// dual-port RAM write-port sequencer.
package dpram_loader_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_LOAD  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    function automatic int bytes_per_word(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/dpram_loader.sv
// dpram_loader: clears a dual-port RAM after reset or on request, then
// packs the byte download stream into RAM words on port A.
module dpram_loader
    import dpram_loader_pkg::*;
#(
    parameter int                    address_width = 10,
    parameter int                    data_width    = 8,
    parameter logic [24:0]           base_addr     = 25'h0,
    parameter logic [data_width-1:0] clear_value   = '0
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     clear_req,
    input  logic                     dl_active,
    input  logic                     dl_wr,
    input  logic [24:0]              dl_addr,
    input  logic [7:0]               dl_data,
    output logic                     dl_wait,
    output logic                     ram_wren,
    output logic [address_width-1:0] ram_address,
    output logic [data_width-1:0]    ram_data,
    output logic                     busy,
    output logic                     done,
    output logic                     overrun
);

    localparam int          BPW   = bytes_per_word(data_width);
    localparam logic [25:0] WIN   = 26'(BPW) << address_width;
    localparam logic [15:0] CLR16 = 16'(clear_value);

    generate
        if (data_width != 8 && data_width != 16) begin : g_bad_width
            $error("dpram_loader: data_width must be 8 or 16");
        end
    endgenerate

    state_t                   state;
    logic [address_width-1:0] cnt;
    logic                     done_pend;
    logic                     stg_valid;
    logic [address_width-1:0] stg_addr;
    logic [7:0]               stg_byte;

    logic [24:0]              off;
    logic                     in_win;
    logic                     lane;
    logic [address_width-1:0] waddr;
    logic                     take;

    always_comb begin
        off    = dl_addr - base_addr;
        in_win = (dl_addr >= base_addr) && ({1'b0, off} < WIN);
        lane   = (BPW == 2) && off[0];
        waddr  = (BPW == 2) ? off[address_width:1]
                            : off[address_width-1:0];
        take   = dl_active && dl_wr && in_win &&
                 (state == ST_IDLE || state == ST_LOAD);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= ST_CLEAR;
            cnt         <= '0;
            done_pend   <= 1'b0;
            stg_valid   <= 1'b0;
            stg_addr    <= '0;
            stg_byte    <= '0;
            dl_wait     <= 1'b1;
            ram_wren    <= 1'b0;
            ram_address <= '0;
            ram_data    <= clear_value;
            busy        <= 1'b1;
            done        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            ram_wren  <= 1'b0;
            done      <= done_pend;
            done_pend <= 1'b0;
            if (dl_wr && dl_wait)
                overrun <= 1'b1;

            // Byte decode; a write lands one cycle after the completing byte.
            if (take) begin
                if (BPW == 1) begin
                    ram_wren    <= 1'b1;
                    ram_address <= waddr;
                    ram_data    <= data_width'(dl_data);
                end else if (lane) begin
                    ram_wren    <= 1'b1;
                    ram_address <= waddr;
                    if (stg_valid && stg_addr == waddr) begin
                        ram_data  <= data_width'({dl_data, stg_byte});
                        stg_valid <= 1'b0;
                    end else begin
                        ram_data <= data_width'({dl_data, CLR16[7:0]});
                    end
                end else begin
                    if (stg_valid && stg_addr != waddr) begin
                        ram_wren    <= 1'b1;
                        ram_address <= stg_addr;
                        ram_data    <= data_width'({CLR16[15:8], stg_byte});
                    end
                    stg_valid <= 1'b1;
                    stg_addr  <= waddr;
                    stg_byte  <= dl_data;
                end
            end

            unique case (state)
                ST_CLEAR: begin
                    ram_wren    <= 1'b1;
                    ram_address <= cnt;
                    ram_data    <= clear_value;
                    cnt         <= cnt + 1'b1;
                    if (cnt == '1) begin
                        state     <= ST_IDLE;
                        dl_wait   <= 1'b0;
                        busy      <= 1'b0;
                        done_pend <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (dl_active) begin
                        state <= ST_LOAD;
                        busy  <= 1'b1;
                    end else if (clear_req) begin
                        state   <= ST_CLEAR;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        dl_wait <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (!dl_active) begin
                        if (stg_valid) begin
                            state   <= ST_FLUSH;
                            dl_wait <= 1'b1;
                        end else begin
                            state     <= ST_IDLE;
                            busy      <= 1'b0;
                            done_pend <= 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    ram_wren    <= 1'b1;
                    ram_address <= stg_addr;
                    ram_data    <= data_width'({CLR16[15:8], stg_byte});
                    stg_valid   <= 1'b0;
                    state       <= ST_IDLE;
                    dl_wait     <= 1'b0;
                    busy        <= 1'b0;
                    done_pend   <= 1'b1;
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_dpram_loader.sv
// tb_dpram_loader: directed scoreboard bench driving an 8-bit and a
// 16-bit loader from one shared download stream.
module tb_dpram_loader;

    typedef struct {
        int unsigned a;
        int unsigned d;
        int          c;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        clear_req;
    logic        dl_active;
    logic        dl_wr;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;

    logic        wait8, wren8, busy8, done8, ovr8;
    logic [3:0]  addr8;
    logic [7:0]  data8;
    logic        wait16, wren16, busy16, done16, ovr16;
    logic [3:0]  addr16;
    logic [15:0] data16;

    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;
    exp_t q8[$];
    exp_t q16[$];

    always @(posedge clk) cyc <= cyc + 1;

    dpram_loader #(
        .address_width(4),
        .data_width(8),
        .base_addr(25'h100),
        .clear_value(8'hA5)
    ) u8 (
        .clock(clk),
        .reset_n(reset_n),
        .clear_req(clear_req),
        .dl_active(dl_active),
        .dl_wr(dl_wr),
        .dl_addr(dl_addr),
        .dl_data(dl_data),
        .dl_wait(wait8),
        .ram_wren(wren8),
        .ram_address(addr8),
        .ram_data(data8),
        .busy(busy8),
        .done(done8),
        .overrun(ovr8)
    );

    dpram_loader #(
        .address_width(4),
        .data_width(16),
        .base_addr(25'h0),
        .clear_value(16'hC35A)
    ) u16 (
        .clock(clk),
        .reset_n(reset_n),
        .clear_req(clear_req),
        .dl_active(dl_active),
        .dl_wr(dl_wr),
        .dl_addr(dl_addr),
        .dl_data(dl_data),
        .dl_wait(wait16),
        .ram_wren(wren16),
        .ram_address(addr16),
        .ram_data(data16),
        .busy(busy16),
        .done(done16),
        .overrun(ovr16)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : mon8
        exp_t e;
        if (wren8 === 1'b1) begin
            chk("wr8 expected", 32'(q8.size() != 0), 1);
            if (q8.size() != 0) begin
                e = q8.pop_front();
                chk("wr8 addr", 32'(addr8), e.a);
                chk("wr8 data", 32'(data8), e.d);
                chk("wr8 cycle", cyc, e.c);
            end
        end
    end

    always @(negedge clk) begin : mon16
        exp_t e;
        if (wren16 === 1'b1) begin
            chk("wr16 expected", 32'(q16.size() != 0), 1);
            if (q16.size() != 0) begin
                e = q16.pop_front();
                chk("wr16 addr", 32'(addr16), e.a);
                chk("wr16 data", 32'(data16), e.d);
                chk("wr16 cycle", cyc, e.c);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [24:0] a, input logic [7:0] d);
        dl_wr   = 1'b1;
        dl_addr = a;
        dl_data = d;
        step();
        dl_wr   = 1'b0;
    endtask

    task automatic push_clear(input int c0);
        for (int i = 0; i < 16; i++) begin
            q8.push_back('{i, 'hA5, c0 + i});
            q16.push_back('{i, 'hC35A, c0 + i});
        end
    endtask

    task automatic wait_done(input bit sel, input int exp_c,
                             input string tag);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(sel ? done16 : done8) && k < 60);
        chk(tag, cyc, exp_c);
    endtask

    initial begin : stim
        int r;
        int d;
        reset_n   = 1'b0;
        clear_req = 1'b0;
        dl_active = 1'b0;
        dl_wr     = 1'b0;
        dl_addr   = '0;
        dl_data   = '0;

        repeat (3) step();
        @(negedge clk);
        chk("rst wren", 32'(wren8), 0);
        chk("rst addr", 32'(addr8), 0);
        chk("rst data8", 32'(data8), 'hA5);
        chk("rst data16", 32'(data16), 'hC35A);
        chk("rst wait", 32'(wait8), 1);
        chk("rst busy", 32'(busy16), 1);
        chk("rst done", 32'(done8), 0);
        chk("rst overrun", 32'(ovr16), 0);

        // Auto-clear after reset.
        step();
        reset_n = 1'b1;
        r = cyc;
        push_clear(r + 1);
        repeat (8) @(negedge clk);
        chk("clr wait mid", 32'(wait8), 1);
        chk("clr busy mid", 32'(busy16), 1);
        wait_done(0, r + 17, "clr done8 cycle");
        chk("clr done16", 32'(done16), 1);
        chk("clr wait idle", 32'(wait16), 0);
        chk("clr busy idle", 32'(busy8), 0);

        // 8-bit stream with window edges.
        step();
        dl_active = 1'b1;
        step();
        q8.push_back('{0, 'h11, cyc + 1});
        send(25'h100, 8'h11);
        q8.push_back('{1, 'h22, cyc + 1});
        send(25'h101, 8'h22);
        q8.push_back('{2, 'h33, cyc + 1});
        send(25'h102, 8'h33);
        q8.push_back('{3, 'h44, cyc + 1});
        send(25'h103, 8'h44);
        send(25'h0FF, 8'hEE);
        send(25'h110, 8'hDD);
        dl_active = 1'b0;
        d = cyc;
        wait_done(0, d + 2, "ld8 done cycle");
        chk("ld8 done16", 32'(done16), 1);
        chk("ld8 hold addr", 32'(addr8), 3);
        chk("ld8 hold data", 32'(data8), 'h44);

        // 16-bit packing, lane-1 mismatch, lane-0 replacement, end flush.
        step();
        dl_active = 1'b1;
        step();
        send(25'h000, 8'h34);
        q16.push_back('{0, 'h1234, cyc + 1});
        send(25'h001, 8'h12);
        q16.push_back('{3, 'h775A, cyc + 1});
        send(25'h007, 8'h77);
        send(25'h008, 8'h88);
        q16.push_back('{4, 'hC388, cyc + 1});
        send(25'h00A, 8'h99);
        dl_active = 1'b0;
        d = cyc;
        q16.push_back('{5, 'hC399, d + 2});
        wait_done(0, d + 2, "ld16a done8 cycle");
        wait_done(1, d + 3, "ld16a done16 cycle");

        // Single lane-0 byte flushed at end of download.
        step();
        dl_active = 1'b1;
        step();
        send(25'h004, 8'h4B);
        dl_active = 1'b0;
        d = cyc;
        q16.push_back('{2, 'hC34B, d + 2});
        wait_done(0, d + 2, "flush done8 cycle");
        wait_done(1, d + 3, "flush done16 cycle");
        chk("flush busy", 32'(busy16), 0);
        chk("flush wait", 32'(wait16), 0);

        // Download attempted during a requested clear.
        chk("pre overrun", 32'(ovr8), 0);
        step();
        clear_req = 1'b1;
        r = cyc;
        step();
        clear_req = 1'b0;
        push_clear(r + 2);
        step();
        step();
        dl_active = 1'b1;
        send(25'h101, 8'h66);
        step();
        send(25'h001, 8'h67);
        wait_done(0, r + 18, "req clr done8 cycle");
        chk("req clr done16", 32'(done16), 1);
        chk("overrun8", 32'(ovr8), 1);
        chk("overrun16", 32'(ovr16), 1);
        step();
        q8.push_back('{2, 'h5C, cyc + 1});
        send(25'h102, 8'h5C);

        // Reset mid-load with a staged lane-0 byte.
        send(25'h006, 8'h66);
        reset_n = 1'b0;
        r = cyc;
        step();
        reset_n = 1'b1;
        push_clear(r + 2);
        @(negedge clk);
        chk("rst2 wren", 32'(wren16), 0);
        chk("rst2 overrun", 32'(ovr16), 0);
        chk("rst2 busy", 32'(busy16), 1);
        chk("rst2 data", 32'(data16), 'hC35A);
        wait_done(0, r + 18, "rst2 clr done8 cycle");
        chk("rst2 clr done16", 32'(done16), 1);
        step();
        dl_active = 1'b0;
        d = cyc;
        wait_done(0, d + 2, "rst2 ld done8 cycle");
        chk("rst2 no flush done16", 32'(done16), 1);

        step();
        step();
        chk("q8 drained", q8.size(), 0);
        chk("q16 drained", q16.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
